// File: rtl/vga_sync_timing.sv
// vga_sync_timing
//   VGA raster timing generator. A pixel-tick divider drives a free-running
//   horizontal/vertical counter pair; sync, blanking and coordinates are decoded
//   from the counters and registered, so outputs lag counter state by one clk.
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous reset, active-low
//   hsync        out  horizontal sync, active-low
//   vsync        out  vertical sync, active-low
//   video_on     out  high inside the active area
//   col          out  active column (0 when blanked)
//   row          out  active row (0 when blanked)
//   pix_tick     out  one-clk strobe on the last clk of each pixel period
//   frame_start  out  one-clk strobe when outputs first show pixel (0,0)
module vga_sync_timing #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] col,
  output logic [8:0] row,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  logic tick_c;
  logic h_last_c;
  logic v_last_c;
  logic hsync_c;
  logic vsync_c;
  logic active_c;
  logic origin_c;

  // Pixel tick fires on the last system clock of each pixel period
  assign tick_c   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign h_last_c = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_last_c = (v_cnt == CNT_W'(V_TOTAL - 1));

  // Counter chain: divider -> column -> line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      if (tick_c) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (tick_c) begin
        if (h_last_c) begin
          h_cnt <= '0;
          // Line wraps on the same edge as the column at frame end
          if (v_last_c) begin
            v_cnt <= '0;
          end else begin
            v_cnt <= v_cnt + CNT_W'(1);
          end
        end else begin
          h_cnt <= h_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Decode of the current counter state
  always_comb begin
    hsync_c  = 1'b1;
    vsync_c  = 1'b1;
    active_c = 1'b0;
    origin_c = 1'b0;
    if ((h_cnt >= CNT_W'(HS_BEG)) && (h_cnt < CNT_W'(HS_END))) begin
      hsync_c = 1'b0;
    end
    if ((v_cnt >= CNT_W'(VS_BEG)) && (v_cnt < CNT_W'(VS_END))) begin
      vsync_c = 1'b0;
    end
    if ((h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE))) begin
      active_c = 1'b1;
    end
    if ((h_cnt == '0) && (v_cnt == '0) && (div_cnt == '0)) begin
      origin_c = 1'b1;
    end
  end

  // Output register stage; coordinates are blanked to zero outside the active area
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      col         <= '0;
      row         <= '0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hsync_c;
      vsync       <= vsync_c;
      video_on    <= active_c;
      col         <= active_c ? h_cnt : '0;
      row         <= active_c ? v_cnt[8:0] : '0;
      pix_tick    <= tick_c;
      frame_start <= origin_c;
    end
  end

endmodule

// File: tb/tb_vga_sync_timing.sv
// tb_vga_sync_timing
//   Bench for vga_sync_timing. Three instances share one clock: defaults (a),
//   a scaled-down raster for frame-level timing (b) and the tiny raster (c).
//   Expected outputs come from a closed-form model: after k clks out of reset
//   the pixel index is k/CLK_DIV, column and line follow by division/modulo.
module tb_vga_sync_timing;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] col;
    logic [8:0] row;
    logic       tick;
    logic       fs;
  } obs_t;

  localparam obs_t RST_OBS = {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logic hs_a, vs_a, von_a, tk_a, fs_a;
  logic [9:0] col_a;
  logic [8:0] row_a;
  logic hs_b, vs_b, von_b, tk_b, fs_b;
  logic [9:0] col_b;
  logic [8:0] row_b;
  logic hs_c, vs_c, von_c, tk_c, fs_c;
  logic [9:0] col_c;
  logic [8:0] row_c;

  obs_t obs_a, obs_b, obs_c;
  assign obs_a = {hs_a, vs_a, von_a, col_a, row_a, tk_a, fs_a};
  assign obs_b = {hs_b, vs_b, von_b, col_b, row_b, tk_b, fs_b};
  assign obs_c = {hs_c, vs_c, von_c, col_c, row_c, tk_c, fs_c};

  vga_sync_timing u_a (
    .clk(clk), .rst_n(rst_a), .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
    .col(col_a), .row(row_a), .pix_tick(tk_a), .frame_start(fs_a)
  );

  vga_sync_timing #(
    .CLK_DIV(2), .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(5)
  ) u_b (
    .clk(clk), .rst_n(rst_b), .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
    .col(col_b), .row(row_b), .pix_tick(tk_b), .frame_start(fs_b)
  );

  vga_sync_timing #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_c (
    .clk(clk), .rst_n(rst_c), .hsync(hs_c), .vsync(vs_c), .video_on(von_c),
    .col(col_c), .row(row_c), .pix_tick(tk_c), .frame_start(fs_c)
  );

  // Reference raster: outputs seen after the k-th clk following reset release
  function automatic obs_t model(int unsigned cd, int unsigned ha, int unsigned hf,
                                 int unsigned hsw, int unsigned hb, int unsigned va,
                                 int unsigned vf, int unsigned vsw, int unsigned vb,
                                 int unsigned k);
    obs_t r;
    int unsigned htot = ha + hf + hsw + hb;
    int unsigned vtot = va + vf + vsw + vb;
    int unsigned p = k / cd;
    int unsigned h = p % htot;
    int unsigned v = (p / htot) % vtot;
    r.hs   = !((h >= ha + hf) && (h < ha + hf + hsw));
    r.vs   = !((v >= va + vf) && (v < va + vf + vsw));
    r.von  = (h < ha) && (v < va);
    r.col  = r.von ? 10'(h) : 10'd0;
    r.row  = r.von ? 9'(v) : 9'd0;
    r.tick = (k % cd) == (cd - 1);
    r.fs   = (k % (cd * htot * vtot)) == 0;
    return r;
  endfunction

  function automatic obs_t model_a(int unsigned k);
    return model(2, 640, 16, 96, 48, 480, 10, 2, 33, k);
  endfunction

  function automatic obs_t model_b(int unsigned k);
    return model(2, 40, 4, 8, 4, 30, 3, 2, 5, k);
  endfunction

  function automatic obs_t model_c(int unsigned k);
    return model(1, 4, 1, 2, 1, 3, 1, 1, 1, k);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset hold, reset values, then first clk after release
  task automatic test_reset();
    int unsigned hold = 5 + $urandom_range(0, 3);
    rst_a = 1'b0;
    for (int i = 0; i < int'(hold); i++) begin
      step();
      n_cmp++;
      if (obs_a !== RST_OBS) begin
        n_fail++;
        $display("FAIL reset_hold clk=%0d got=%h exp=%h", i, obs_a, RST_OBS);
      end
    end
    rst_a = 1'b1;
    step();
    n_cmp++;
    if (!(von_a === 1'b1 && fs_a === 1'b1 && col_a === 10'd0 && row_a === 9'd0)) begin
      n_fail++;
      $display("FAIL reset_release got von=%b fs=%b col=%0d row=%0d exp von=1 fs=1 col=0 row=0",
               von_a, fs_a, col_a, row_a);
    end
    n_cmp++;
    if (obs_a !== model_a(0)) begin
      n_fail++;
      $display("FAIL reset_release_all got=%h exp=%h", obs_a, model_a(0));
    end
  endtask

  // Two full lines of the default raster, plus line-level aggregates
  task automatic test_line_timing();
    int von_cnt = 0;
    int hlow_cnt = 0;
    int hlow_first = -1;
    int line_fails = 0;
    rst_a = 1'b0;
    step();
    rst_a = 1'b1;
    for (int unsigned k = 0; k < 3200; k++) begin
      step();
      if (obs_a !== model_a(k)) begin
        line_fails++;
        $display("FAIL line_model k=%0d got=%h exp=%h", k, obs_a, model_a(k));
      end
      if (k < 1600) begin
        if (von_a) von_cnt++;
        if (!hs_a) begin
          hlow_cnt++;
          if (hlow_first < 0) hlow_first = int'(k);
        end
      end
    end
    n_cmp++;
    if (line_fails != 0) n_fail++;
    n_cmp++;
    if (von_cnt != 1280) begin
      n_fail++;
      $display("FAIL line_video_on got=%0d exp=1280", von_cnt);
    end
    n_cmp++;
    if (hlow_cnt != 192) begin
      n_fail++;
      $display("FAIL line_hsync_width got=%0d exp=192", hlow_cnt);
    end
    n_cmp++;
    if (hlow_first != 1312) begin
      n_fail++;
      $display("FAIL line_hsync_start got=%0d exp=1312", hlow_first);
    end
  endtask

  // Scaled raster: 56x40 pixels, 2 clks/pixel -> 4480 clks per frame
  task automatic test_frame_timing();
    int vlow_cnt = 0;
    int vlow_first = -1;
    int von_cnt = 0;
    int fs_cnt = 0;
    int fs_last = -1;
    int fs_gap = -1;
    int max_col = 0;
    int max_row = 0;
    int blank_bad = 0;
    int frame_fails = 0;
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    for (int unsigned k = 0; k < 9060; k++) begin
      step();
      if (obs_b !== model_b(k)) begin
        frame_fails++;
        $display("FAIL frame_model k=%0d got=%h exp=%h", k, obs_b, model_b(k));
      end
      if (k < 4480) begin
        if (!vs_b) begin
          vlow_cnt++;
          if (vlow_first < 0) vlow_first = int'(k);
        end
        if (von_b) von_cnt++;
      end
      if (fs_b) begin
        fs_cnt++;
        if (fs_last >= 0) fs_gap = int'(k) - fs_last;
        fs_last = int'(k);
      end
      if (int'(col_b) > max_col) max_col = int'(col_b);
      if (int'(row_b) > max_row) max_row = int'(row_b);
      if (!von_b && (col_b != 10'd0 || row_b != 9'd0)) blank_bad++;
    end
    n_cmp++;
    if (frame_fails != 0) n_fail++;
    n_cmp++;
    if (vlow_cnt != 224) begin
      n_fail++;
      $display("FAIL frame_vsync_width got=%0d exp=224", vlow_cnt);
    end
    n_cmp++;
    if (vlow_first != 3696) begin
      n_fail++;
      $display("FAIL frame_vsync_start got=%0d exp=3696", vlow_first);
    end
    n_cmp++;
    if (von_cnt != 2400) begin
      n_fail++;
      $display("FAIL frame_active_count got=%0d exp=2400", von_cnt);
    end
    n_cmp++;
    if (fs_cnt != 3 || fs_gap != 4480) begin
      n_fail++;
      $display("FAIL frame_start_period got cnt=%0d gap=%0d exp cnt=3 gap=4480", fs_cnt, fs_gap);
    end
    n_cmp++;
    if (max_col != 39 || max_row != 29) begin
      n_fail++;
      $display("FAIL frame_max_coord got col=%0d row=%0d exp col=39 row=29", max_col, max_row);
    end
    n_cmp++;
    if (blank_bad != 0) begin
      n_fail++;
      $display("FAIL frame_blank_zero got=%0d exp=0", blank_bad);
    end
  endtask

  // One-clk reset at (row 20, col 30), then randomly placed resets
  task automatic test_mid_frame_reset();
    int unsigned run;
    int unsigned hold;
    int tail_fails = 0;
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    for (int unsigned k = 0; k < 2300; k++) step();
    n_cmp++;
    step();
    if (!(von_b === 1'b1 && col_b === 10'd30 && row_b === 9'd20)) begin
      n_fail++;
      $display("FAIL midreset_position got col=%0d row=%0d exp col=30 row=20", col_b, row_b);
    end
    for (int it = 0; it < 6; it++) begin
      hold = (it == 0) ? 1 : $urandom_range(1, 3);
      rst_b = 1'b0;
      for (int unsigned i = 0; i < hold; i++) begin
        step();
        n_cmp++;
        if (obs_b !== RST_OBS) begin
          n_fail++;
          $display("FAIL midreset_hold it=%0d got=%h exp=%h", it, obs_b, RST_OBS);
        end
      end
      rst_b = 1'b1;
      step();
      n_cmp++;
      if (!(fs_b === 1'b1 && von_b === 1'b1 && col_b === 10'd0 && row_b === 9'd0)) begin
        n_fail++;
        $display("FAIL midreset_restart it=%0d got fs=%b von=%b col=%0d row=%0d exp fs=1 von=1 col=0 row=0",
                 it, fs_b, von_b, col_b, row_b);
      end
      run = $urandom_range(1, 5000);
      for (int unsigned k = 1; k < run; k++) begin
        step();
        if (obs_b !== model_b(k)) begin
          tail_fails++;
          $display("FAIL midreset_run it=%0d k=%0d got=%h exp=%h", it, k, obs_b, model_b(k));
        end
      end
    end
    n_cmp++;
    if (tail_fails != 0) n_fail++;
  endtask

  // Tiny raster, CLK_DIV=1: every clk compared for three frames
  task automatic test_small_exhaustive();
    int fs_cnt = 0;
    int von_cnt = 0;
    int small_fails = 0;
    rst_c = 1'b0;
    step();
    rst_c = 1'b1;
    for (int unsigned k = 0; k < 144; k++) begin
      step();
      if (obs_c !== model_c(k)) begin
        small_fails++;
        $display("FAIL small_model k=%0d got=%h exp=%h", k, obs_c, model_c(k));
      end
      if (fs_c) fs_cnt++;
      if (von_c) von_cnt++;
    end
    n_cmp++;
    if (small_fails != 0) n_fail++;
    n_cmp++;
    if (fs_cnt != 3) begin
      n_fail++;
      $display("FAIL small_frame_count got=%0d exp=3", fs_cnt);
    end
    n_cmp++;
    if (von_cnt != 36) begin
      n_fail++;
      $display("FAIL small_active_count got=%0d exp=36", von_cnt);
    end
    n_cmp++;
    if (tk_c !== 1'b1) begin
      n_fail++;
      $display("FAIL small_tick_every_clk got=%b exp=1", tk_c);
    end
  endtask

  initial begin
    step();
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_mid_frame_reset();
    test_small_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
